// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: arbiter state enum, default parameters and modular index helper
package fifo_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_MAX_BURST = 4;
  function automatic int wrap_idx(input int a, input int n);
    return a >= n ? a - n : a;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker (valid, ptr -> any, idx of first valid from ptr upward, wrapping)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = DEF_NUM_REQ,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);
  always_comb begin
    any = |valid;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (valid[wrap_idx(int'(ptr) + k, N)]) idx = IW'(wrap_idx(int'(ptr) + k, N));
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter of NUM_REQ valid/ready writers onto one FIFO write port (clk, rst_n, req_*, fifo_*, grant_id, busy)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST,
  localparam int IW = $clog2(NUM_REQ),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy
);
  state_t state;
  logic [IW-1:0] owner, rr_ptr, rr_nxt, pick;
  logic [BW-1:0] burst_cnt;
  logic grant, own_valid, xfer, rel, any;
  assign grant = state == GRANT;
  assign own_valid = req_valid[owner];
  assign xfer = grant && own_valid && !fifo_full;
  assign rel = grant && (!own_valid || (xfer && burst_cnt == BW'(MAX_BURST - 1)));
  assign rr_nxt = owner == IW'(NUM_REQ - 1) ? '0 : owner + IW'(1);
  rr_pick #(.N(NUM_REQ)) u_pick (
    .valid(req_valid),
    .ptr  (rel ? rr_nxt : rr_ptr),
    .any  (any),
    .idx  (pick)
  );
  always_comb begin
    req_ready = '0;
    req_ready[owner] = grant && !fifo_full;
  end
  assign fifo_wr_en = xfer;
  assign fifo_data_in = grant ? req_data[owner*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign grant_id = owner;
  assign busy = grant;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      burst_cnt <= '0;
    end else if (!grant || rel) begin
      if (rel) rr_ptr <= rr_nxt;
      state <= any ? GRANT : IDLE;
      if (any) owner <= pick;
      burst_cnt <= '0;
    end else if (xfer) begin
      burst_cnt <= burst_cnt + BW'(1);
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter (default and NUM_REQ=3 instances)
module tb_fifo_wr_arbiter;
  logic clk = 0, rst_n = 0, fifo_full = 0;
  logic [3:0] req_valid = '0, req_ready;
  logic [23:0] req_data = '0;
  logic fifo_wr_en, busy;
  logic [5:0] fifo_data_in;
  logic [1:0] grant_id;
  logic [2:0] req_valid3 = '0, req_ready3;
  logic [17:0] req_data3 = '0;
  logic wr_en3, busy3;
  logic [5:0] data3;
  logic [1:0] grant_id3;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fifo_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .grant_id(grant_id), .busy(busy)
  );
  fifo_wr_arbiter #(.NUM_REQ(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_data(req_data3), .req_ready(req_ready3),
    .fifo_full(fifo_full), .fifo_wr_en(wr_en3), .fifo_data_in(data3),
    .grant_id(grant_id3), .busy(busy3)
  );
  task automatic do_reset;
    req_valid = '0;
    req_valid3 = '0;
    fifo_full = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_reset;
    req_valid = 4'b1111;
    req_data = {6'd13, 6'd12, 6'd11, 6'd10};
    @(negedge clk);
    #1;
    checks++;
    if ({busy, grant_id, req_ready, fifo_wr_en, fifo_data_in} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b gid=%0d rdy=%b wr=%b data=%0d want all 0", busy, grant_id, req_ready, fifo_wr_en, fifo_data_in);
    end
    checks++;
    if ({busy3, grant_id3, req_ready3, wr_en3, data3} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs3: got busy=%b gid=%0d rdy=%b wr=%b want all 0", busy3, grant_id3, req_ready3, wr_en3);
    end
  endtask
  task automatic test_single;
    int k = 0;
    do_reset();
    req_data = '0;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_first_cycle: got rdy=%b busy=%b want 0000 0", req_ready, busy);
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      req_data[5:0] = 6'(k);
      #1;
      checks++;
      if (fifo_wr_en !== 1'b1 || fifo_data_in !== 6'(k) || req_ready !== 4'b0001 || grant_id !== 2'd0) begin
        errors++;
        $display("FAIL single_word%0d: got wr=%b data=%0d rdy=%b gid=%0d want 1 %0d 0001 0", c, fifo_wr_en, fifo_data_in, req_ready, grant_id, k);
      end
      k++;
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || fifo_data_in !== 6'd0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL single_idle: got busy=%b wr=%b data=%0d gid=%0d want 0 0 0 0", busy, fifo_wr_en, fifo_data_in, grant_id);
    end
  endtask
  task automatic test_all_valid;
    do_reset();
    req_data = {6'd13, 6'd12, 6'd11, 6'd10};
    req_valid = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      int e = ((c - 1) / 4) % 4;
      @(negedge clk);
      #1;
      checks++;
      if (grant_id !== 2'(e) || busy !== 1'b1 || fifo_wr_en !== 1'b1 || fifo_data_in !== 6'(10 + e)) begin
        errors++;
        $display("FAIL all_cycle%0d: got gid=%0d busy=%b wr=%b data=%0d want %0d 1 1 %0d", c, grant_id, busy, fifo_wr_en, fifo_data_in, e, 10 + e);
      end
    end
  endtask
  task automatic test_fifo_full;
    logic [7:0] wr_tbl = 8'b1110_0011;
    do_reset();
    req_data = {6'd0, 6'd0, 6'd21, 6'd20};
    req_valid = 4'b0011;
    for (int c = 1; c <= 8; c++) begin
      logic [3:0] rdy;
      logic [1:0] g;
      @(negedge clk);
      fifo_full = c >= 3 && c <= 5;
      #1;
      g = c == 8 ? 2'd1 : 2'd0;
      rdy = fifo_full ? 4'b0000 : (c == 8 ? 4'b0010 : 4'b0001);
      checks++;
      if (fifo_wr_en !== wr_tbl[c-1] || req_ready !== rdy || grant_id !== g || busy !== 1'b1 ||
          (wr_tbl[c-1] && fifo_data_in !== 6'(20 + int'(g)))) begin
        errors++;
        $display("FAIL full_cycle%0d: got wr=%b rdy=%b gid=%0d busy=%b data=%0d want %b %b %0d 1 %0d", c, fifo_wr_en, req_ready, grant_id, busy, fifo_data_in, wr_tbl[c-1], rdy, g, 20 + int'(g));
      end
    end
    fifo_full = 0;
  endtask
  task automatic test_drop;
    do_reset();
    req_data = {6'd33, 6'd32, 6'd31, 6'd30};
    req_valid = 4'b0100;
    @(negedge clk);
    #1;
    checks++;
    if (grant_id !== 2'd2 || fifo_wr_en !== 1'b1 || fifo_data_in !== 6'd32) begin
      errors++;
      $display("FAIL drop_first: got gid=%0d wr=%b data=%0d want 2 1 32", grant_id, fifo_wr_en, fifo_data_in);
    end
    @(negedge clk);
    req_valid = 4'b1001;
    #1;
    checks++;
    if (grant_id !== 2'd2 || fifo_wr_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_release: got gid=%0d wr=%b busy=%b want 2 0 1", grant_id, fifo_wr_en, busy);
    end
    for (int c = 3; c <= 7; c++) begin
      int e = c == 7 ? 0 : 3;
      @(negedge clk);
      #1;
      checks++;
      if (grant_id !== 2'(e) || fifo_wr_en !== 1'b1 || fifo_data_in !== 6'(30 + e)) begin
        errors++;
        $display("FAIL drop_cycle%0d: got gid=%0d wr=%b data=%0d want %0d 1 %0d", c, grant_id, fifo_wr_en, fifo_data_in, e, 30 + e);
      end
    end
  endtask
  task automatic test_three;
    do_reset();
    req_data3 = {6'd42, 6'd41, 6'd40};
    req_valid3 = 3'b111;
    for (int c = 1; c <= 16; c++) begin
      int e = ((c - 1) / 4) % 3;
      @(negedge clk);
      #1;
      checks++;
      if (grant_id3 !== 2'(e) || wr_en3 !== 1'b1 || data3 !== 6'(40 + e) || busy3 !== 1'b1) begin
        errors++;
        $display("FAIL three_cycle%0d: got gid=%0d wr=%b data=%0d busy=%b want %0d 1 %0d 1", c, grant_id3, wr_en3, data3, busy3, e, 40 + e);
      end
    end
  endtask
  task automatic test_async_reset;
    do_reset();
    req_data = {6'd13, 6'd12, 6'd11, 6'd10};
    req_valid = 4'b1111;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (grant_id !== 2'd1 || fifo_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL arst_before: got gid=%0d wr=%b want 1 1", grant_id, fifo_wr_en);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({busy, fifo_wr_en, req_ready, grant_id, fifo_data_in} !== 14'd0) begin
      errors++;
      $display("FAIL arst_immediate: got busy=%b wr=%b rdy=%b gid=%0d data=%0d want all 0", busy, fifo_wr_en, req_ready, grant_id, fifo_data_in);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL arst_release_idle: got busy=%b wr=%b want 0 0", busy, fifo_wr_en);
    end
    @(negedge clk);
    #1;
    checks++;
    if (grant_id !== 2'd0 || busy !== 1'b1 || fifo_wr_en !== 1'b1 || fifo_data_in !== 6'd10) begin
      errors++;
      $display("FAIL arst_regrant: got gid=%0d busy=%b wr=%b data=%0d want 0 1 1 10", grant_id, busy, fifo_wr_en, fifo_data_in);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_fifo_full();
    test_drop();
    test_three();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
